// File: rtl/pipelined_cla_addsub_pkg.sv
// Shared ALU definitions for the pipelined CLA adder/subtractor:
// status flag bit positions and the lookahead group size.
package pipelined_cla_addsub_pkg;

   localparam int CLA_GRP   = 4;

   localparam int FLAG_C    = 0;
   localparam int FLAG_V    = 1;
   localparam int FLAG_Z    = 2;
   localparam int FLAG_N    = 3;
   localparam int NUM_FLAGS = 4;

   typedef logic [NUM_FLAGS-1:0] alu_flags_t;

endpackage

// File: rtl/pipelined_cla_addsub_cla_segment.sv
// Combinational SEG-bit two-level carry-lookahead adder: 4-bit groups with P/G,
// then a lookahead level across the groups (no ripple between groups).
module cla_segment
   import pipelined_cla_addsub_pkg::*;
#(
   parameter int SEG = 16
) (
   input  logic           cin,
   input  logic [SEG-1:0] x,
   input  logic [SEG-1:0] y,
   output logic [SEG-1:0] s,
   output logic           cout,
   output logic           c_msb,
   output logic           p,
   output logic           g
);

   localparam int NG = SEG / CLA_GRP;

   logic [SEG-1:0] bp, bg, c;
   logic [NG-1:0]  gp, gg;
   logic [NG:0]    gc;

   // Flat sum-of-products carry into position n: OR over k of (g[k] & p[k+1..n-1]),
   // plus ci & p[0..n-1]. Every carry is built independently, so nothing ripples.
   function automatic logic la_carry(input logic [SEG-1:0] pp, input logic [SEG-1:0] gv,
                                     input logic ci, input int unsigned n);
      logic acc, term;
      acc = ci;
      for (int unsigned i = 0; i < n; i++) acc = acc & pp[i];
      for (int unsigned k = 0; k < n; k++) begin
         term = gv[k];
         for (int unsigned i = k + 1; i < n; i++) term = term & pp[i];
         acc = acc | term;
      end
      return acc;
   endfunction

   always_comb begin
      bp = x ^ y;
      bg = x & y;
      for (int unsigned j = 0; j < NG; j++) begin
         gp[j] = &bp[j*CLA_GRP +: CLA_GRP];
         gg[j] = la_carry(SEG'(bp[j*CLA_GRP +: CLA_GRP]), SEG'(bg[j*CLA_GRP +: CLA_GRP]),
                          1'b0, CLA_GRP);
      end
      for (int unsigned j = 0; j <= NG; j++)
         gc[j] = la_carry(SEG'(gp), SEG'(gg), cin, j);
      c = '0;
      for (int unsigned j = 0; j < NG; j++)
         for (int unsigned b = 0; b < CLA_GRP; b++)
            c[j*CLA_GRP + b] = la_carry(SEG'(bp[j*CLA_GRP +: CLA_GRP]),
                                        SEG'(bg[j*CLA_GRP +: CLA_GRP]), gc[j], b);
   end

   assign s     = bp ^ c;
   assign cout  = gc[NG];
   assign c_msb = c[SEG-1];
   assign p     = &gp;
   assign g     = la_carry(SEG'(gp), SEG'(gg), 1'b0, NG);

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor: segment k is added in stage k with the
// registered carry of segment k-1; valid/ready handshake with a global stall.
module pipelined_cla_addsub
   import pipelined_cla_addsub_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             sub,
   input  logic             cin,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf,
   output logic             zero,
   output logic             neg
);

   localparam int SEG = WIDTH / STAGES;

   // pipe_*[k] is what stage k consumes: ports for k = 0, stage k-1 registers otherwise
   logic [WIDTH-1:0] pipe_x [STAGES];
   logic [WIDTH-1:0] pipe_y [STAGES];
   logic [WIDTH-1:0] pipe_s [STAGES];
   logic             pipe_c [STAGES];
   logic             pipe_z [STAGES];
   logic             pipe_v [STAGES];

   logic             adv;
   logic [WIDTH-1:0] res_d, res_q;
   alu_flags_t       flags_d, flags_q;
   logic             out_valid_d, out_valid_q;

   assign adv      = !out_valid_q | out_ready;
   assign in_ready = adv;

   assign pipe_x[0] = x;
   assign pipe_y[0] = sub ? ~y : y;
   assign pipe_c[0] = sub ? 1'b1 : cin;
   assign pipe_s[0] = '0;
   assign pipe_z[0] = 1'b1;
   assign pipe_v[0] = in_valid;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [SEG-1:0]   seg_s;
      logic             seg_cout, seg_cmsb;
      logic             unused_seg_p, unused_seg_g;
      logic [WIDTH-1:0] sum_d;
      logic             zero_d;

      cla_segment #(.SEG(SEG)) u_seg (
         .cin   (pipe_c[k]),
         .x     (pipe_x[k][k*SEG +: SEG]),
         .y     (pipe_y[k][k*SEG +: SEG]),
         .s     (seg_s),
         .cout  (seg_cout),
         .c_msb (seg_cmsb),
         .p     (unused_seg_p),
         .g     (unused_seg_g)
      );

      always_comb begin
         sum_d                 = pipe_s[k];
         sum_d[k*SEG +: SEG]   = seg_s;
         zero_d                = pipe_z[k] & ~|seg_s;
      end

      if (k < STAGES - 1) begin : g_mid
         logic [WIDTH-1:0] x_q, y_q, sum_q;
         logic             c_q, z_q, v_q;

         always_ff @(posedge clk) begin
            if (rst)      v_q <= 1'b0;
            else if (adv) v_q <= pipe_v[k];
         end

         always_ff @(posedge clk) begin
            if (adv) begin
               x_q   <= pipe_x[k];
               y_q   <= pipe_y[k];
               sum_q <= sum_d;
               c_q   <= seg_cout;
               z_q   <= zero_d;
            end
         end

         assign pipe_x[k+1] = x_q;
         assign pipe_y[k+1] = y_q;
         assign pipe_s[k+1] = sum_q;
         assign pipe_c[k+1] = c_q;
         assign pipe_z[k+1] = z_q;
         assign pipe_v[k+1] = v_q;
      end else begin : g_last
         always_comb begin
            res_d           = sum_d;
            flags_d         = '0;
            flags_d[FLAG_C] = seg_cout;
            flags_d[FLAG_V] = seg_cout ^ seg_cmsb;
            flags_d[FLAG_Z] = zero_d;
            flags_d[FLAG_N] = sum_d[WIDTH-1];
            out_valid_d     = pipe_v[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         res_q       <= '0;
         flags_q     <= '0;
      end else if (adv) begin
         out_valid_q <= out_valid_d;
         res_q       <= res_d;
         flags_q     <= flags_d;
      end
   end

   assign out_valid = out_valid_q;
   assign s         = res_q;
   assign cout      = flags_q[FLAG_C];
   assign ovf       = flags_q[FLAG_V];
   assign zero      = flags_q[FLAG_Z];
   assign neg       = flags_q[FLAG_N];

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Bench for pipelined_cla_addsub: four instances (STAGES 2,1,4,8) share one stimulus
// stream; each has its own arithmetic reference scoreboard.
module tb_pipelined_cla_addsub;

   localparam int W  = 32;
   localparam int NI = 4;

   typedef struct packed {
      logic [35:0] r;   // {cout, ovf, zero, neg, s}
      int          cyc;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid_i, sub_i, cin_i, out_ready_i;
   logic [W-1:0]  x_i, y_i;
   logic          ir_a  [NI];
   logic          ov_a  [NI];
   logic [W-1:0]  s_a   [NI];
   logic [3:0]    fl_a  [NI];
   int            pops_a [NI];
   int            qsz_a  [NI];
   int            cyc = 0;
   bit            lat_chk = 1'b0;
   int            n_checks = 0;
   int            n_errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Plain 33-bit arithmetic; overflow from operand/result signs.
   function automatic logic [35:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sb, input logic ci);
      logic [W:0]   full;
      logic [W-1:0] bb, r;
      logic         v;
      bb   = sb ? ~b : b;
      full = {1'b0, a} + {1'b0, bb} + 33'(sb ? 1'b1 : ci);
      r    = full[W-1:0];
      v    = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
      return {full[W], v, (r == '0), r[W-1], r};
   endfunction

   for (genvar gi = 0; gi < NI; gi++) begin : g_inst
      localparam int ST = (gi == 0) ? 2 : (gi == 1) ? 1 : (gi == 2) ? 4 : 8;
      logic cout_w, ovf_w, zero_w, neg_w;
      exp_t exp_q [$];

      pipelined_cla_addsub #(.WIDTH(W), .STAGES(ST)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid_i),
         .in_ready  (ir_a[gi]),
         .sub       (sub_i),
         .cin       (cin_i),
         .x         (x_i),
         .y         (y_i),
         .out_valid (ov_a[gi]),
         .out_ready (out_ready_i),
         .s         (s_a[gi]),
         .cout      (cout_w),
         .ovf       (ovf_w),
         .zero      (zero_w),
         .neg       (neg_w)
      );

      assign fl_a[gi] = {cout_w, ovf_w, zero_w, neg_w};

      initial pops_a[gi] = 0;

      always @(negedge clk) begin : mon
         exp_t e;
         if (rst) begin
            exp_q.delete();
         end else begin
            if (ov_a[gi] && exp_q.size() == 0) begin
               check($sformatf("st%0d_spurious_valid", ST), 1, 0);
            end else if (ov_a[gi] && out_ready_i) begin
               e = exp_q.pop_front();
               check($sformatf("st%0d_s", ST), s_a[gi], e.r[31:0]);
               check($sformatf("st%0d_flags", ST), fl_a[gi], e.r[35:32]);
               if (lat_chk) check($sformatf("st%0d_latency", ST), cyc - e.cyc, ST);
               pops_a[gi]++;
            end else if (ov_a[gi]) begin
               check($sformatf("st%0d_hold_s", ST), s_a[gi], exp_q[0].r[31:0]);
               check($sformatf("st%0d_hold_flags", ST), fl_a[gi], exp_q[0].r[35:32]);
            end
            if (in_valid_i && ir_a[gi])
               exp_q.push_back('{r: model(x_i, y_i, sub_i, cin_i), cyc: cyc});
         end
         qsz_a[gi] = exp_q.size();
      end
   end

   // Directed beat on the STAGES=2 instance; entered and left just after a rising edge.
   task automatic do_beat(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sb, input logic ci,
                          input logic [W-1:0] es, input logic [3:0] ef);
      x_i = a; y_i = b; sub_i = sb; cin_i = ci; in_valid_i = 1'b1; out_ready_i = 1'b1;
      @(posedge clk); #1;
      in_valid_i = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check({tag, "_valid"}, ov_a[0], 1);
      check({tag, "_s"}, s_a[0], es);
      check({tag, "_flags"}, fl_a[0], ef);
      @(posedge clk); #1;
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         4:       return 32'h0000_FFFF;
         default: return W'($urandom);
      endcase
   endfunction

   task automatic rand_phase(input int n, input bit rdy_rand);
      for (int i = 0; i < n; i++) begin
         x_i         = pick();
         y_i         = pick();
         sub_i       = 1'($urandom_range(0, 1));
         cin_i       = 1'($urandom_range(0, 1));
         in_valid_i  = ($urandom_range(0, 9) < 8);
         out_ready_i = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
         @(posedge clk); #1;
      end
      in_valid_i  = 1'b0;
      out_ready_i = 1'b1;
      repeat (20) @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int p0, t, i;
      rst = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b1;
      sub_i = 1'b0; cin_i = 1'b0; x_i = '0; y_i = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
         check("reset_out_valid", ov_a[k], 0);
         check("reset_s", s_a[k], 0);
         check("reset_flags", fl_a[k], 0);
      end
      @(posedge clk); #1;

      // flags order {cout, ovf, zero, neg}
      do_beat("add_small",   32'h0000_0005, 32'h0000_000B, 1'b0, 1'b0, 32'h0000_0010, 4'b0000);
      do_beat("seg_carry",   32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 4'b0000);
      do_beat("all_ones",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'b1001);
      do_beat("pos_ovf",     32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 4'b0101);
      do_beat("sub_equal",   32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 32'h0000_0000, 4'b1010);
      do_beat("sub_cin_ign", 32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0002, 4'b1000);
      do_beat("sub_borrow",  32'h0000_0003, 32'h0000_0005, 1'b1, 1'b0, 32'hFFFF_FFFE, 4'b0001);
      do_beat("sub_ovf",     32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 4'b1100);

      // back-pressure: beats i+i, consumer stalls during cycles 3..6
      p0 = pops_a[0];
      i = 1; t = 0;
      while (i <= 8 && t < 100) begin
         x_i = W'(i); y_i = W'(i); sub_i = 1'b0; cin_i = 1'b0; in_valid_i = 1'b1;
         out_ready_i = !(t >= 3 && t <= 6);
         @(negedge clk);
         if (t >= 3 && t <= 6) check("bp_in_ready_low", ir_a[0], 0);
         if (ir_a[0]) i++;
         @(posedge clk); #1;
         t++;
      end
      check("bp_all_sent", i, 9);
      in_valid_i = 1'b0; out_ready_i = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      check("bp_beats_out", pops_a[0] - p0, 8);

      // reset with beats in flight
      for (int k = 1; k <= 3; k++) begin
         x_i = W'(32'h100 * k); y_i = W'(k); in_valid_i = 1'b1; out_ready_i = 1'b1;
         @(posedge clk); #1;
      end
      in_valid_i = 1'b0; out_ready_i = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      for (int k = 0; k < NI; k++) check("rst_out_valid", ov_a[k], 0);
      out_ready_i = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("rst_no_ghost", ov_a[0], 0);
      end
      @(posedge clk); #1;

      lat_chk = 1'b1;
      rand_phase(4000, 1'b0);
      lat_chk = 1'b0;
      rand_phase(6000, 1'b1);

      @(negedge clk);
      for (int k = 0; k < NI; k++) check("drain_queue_empty", qsz_a[k], 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
